writeback_regfile: RTL and testbench



---
 rtl/writeback_regfile.sv | 197 +++++++++++++++++++
 tb/tb_writeback_regfile.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// writeback_regfile
// -----------------
// Writeback stage and architectural register file of the sequential Y86-64
// core. Each retiring instruction's destinations (dstE/dstM) are decoded
// here, values are committed on the rising clock edge, and all fifteen
// registers are exported as flops for the decode stage to read.
// Processor status (AOK/HLT/INS) is tracked here as well; once the core
// leaves AOK all architectural state is frozen until reset.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wb_valid   an instruction retires this cycle
//   icode      instruction code
//   cnd        condition outcome from execute (used by cmovXX)
//   rA, rB     register specifiers (4'hF = no register)
//   valE       ALU result
//   valM       memory read data
//   reg_mem0..reg_mem14  registered contents of R0..R14
//   stat       2'b00 AOK, 2'b01 HLT, 2'b10 INS
//   wb_busy    high whenever stat != AOK (commits are blocked)
//   retired    count of committed instructions, wraps at 2^32
//
// Configuration macro
//   WB_RETIRE_CNT_EN  when defined, the 32-bit retired counter is built;
//                     otherwise retired is tied to zero.

module writeback_regfile #(
    parameter int W    = 64,
    parameter int NREG = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wb_valid,
    input  logic [3:0]   icode,
    input  logic         cnd,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    output logic [W-1:0] reg_mem0,
    output logic [W-1:0] reg_mem1,
    output logic [W-1:0] reg_mem2,
    output logic [W-1:0] reg_mem3,
    output logic [W-1:0] reg_mem4,
    output logic [W-1:0] reg_mem5,
    output logic [W-1:0] reg_mem6,
    output logic [W-1:0] reg_mem7,
    output logic [W-1:0] reg_mem8,
    output logic [W-1:0] reg_mem9,
    output logic [W-1:0] reg_mem10,
    output logic [W-1:0] reg_mem11,
    output logic [W-1:0] reg_mem12,
    output logic [W-1:0] reg_mem13,
    output logic [W-1:0] reg_mem14,
    output logic [1:0]   stat,
    output logic         wb_busy,
    output logic [31:0]  retired
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_AOK = 2'b00,
        ST_HLT = 2'b01,
        ST_INS = 2'b10
    } stat_t;

    stat_t stat_reg;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       commit_en;     // instruction may update architectural state
    logic       icode_legal;   // icode 0..B

    logic [W-1:0] regs_reg [NREG];

    // ------------------------------------------------------------------
    // Destination decode
    // ------------------------------------------------------------------
    always_comb begin
        dst_e = REG_NONE;
        case (icode)
            I_CMOVXX:                          dst_e = cnd ? rB : REG_NONE;
            I_IRMOVQ, I_OPQ:                   dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    dst_e = REG_RSP;
            default:                           dst_e = REG_NONE;
        endcase
    end

    always_comb begin
        dst_m = REG_NONE;
        if (icode == I_MRMOVQ || icode == I_POPQ) begin
            dst_m = rA;
        end
    end

    // Writes are only possible in AOK. Halt and illegal icodes decode to
    // no destination, so they never touch the register file here.
    assign commit_en   = wb_valid && (stat_reg == ST_AOK);
    assign icode_legal = (icode <= I_POPQ);

    // ------------------------------------------------------------------
    // Register file: one flop bank per register. When both ports target
    // the same register, the memory port has priority (popq %rsp).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [3:0] IDX = gi[3:0];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (commit_en) begin
                    if (dst_m == IDX) begin
                        regs_reg[gi] <= valM;
                    end else if (dst_e == IDX) begin
                        regs_reg[gi] <= valE;
                    end
                end
            end
        end
    endgenerate

    assign reg_mem0  = regs_reg[0];
    assign reg_mem1  = regs_reg[1];
    assign reg_mem2  = regs_reg[2];
    assign reg_mem3  = regs_reg[3];
    assign reg_mem4  = regs_reg[4];
    assign reg_mem5  = regs_reg[5];
    assign reg_mem6  = regs_reg[6];
    assign reg_mem7  = regs_reg[7];
    assign reg_mem8  = regs_reg[8];
    assign reg_mem9  = regs_reg[9];
    assign reg_mem10 = regs_reg[10];
    assign reg_mem11 = regs_reg[11];
    assign reg_mem12 = regs_reg[12];
    assign reg_mem13 = regs_reg[13];
    assign reg_mem14 = regs_reg[14];

    // ------------------------------------------------------------------
    // Status machine. HLT and INS are absorbing until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reg <= ST_AOK;
        end else begin
            case (stat_reg)
                ST_AOK: begin
                    if (wb_valid) begin
                        if (icode == I_HALT) begin
                            stat_reg <= ST_HLT;
                        end else if (!icode_legal) begin
                            stat_reg <= ST_INS;
                        end
                    end
                end
                ST_HLT:  stat_reg <= ST_HLT;
                ST_INS:  stat_reg <= ST_INS;
                default: stat_reg <= ST_INS;
            endcase
        end
    end

    assign stat    = stat_reg;
    assign wb_busy = (stat_reg != ST_AOK);

    // ------------------------------------------------------------------
    // Retired-instruction counter. Halt counts; illegal icodes do not.
    // ------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= 32'd0;
        end else if (commit_en && icode_legal) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign retired = retired_reg;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Testbench for writeback_regfile: directed vectors with hand-computed
// expectations. The stimulus process pushes the expected architectural
// snapshot after each edge; an independent monitor pops and compares.
module tb_writeback_regfile;

    localparam int W    = 64;
    localparam int NREG = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wb_valid = 1'b0;
    logic [3:0]   icode = 4'h1;
    logic         cnd = 1'b0;
    logic [3:0]   rA = 4'hF;
    logic [3:0]   rB = 4'hF;
    logic [W-1:0] valE = '0;
    logic [W-1:0] valM = '0;
    logic [W-1:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4;
    logic [W-1:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9;
    logic [W-1:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14;
    logic [1:0]   stat;
    logic         wb_busy;
    logic [31:0]  retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_regfile #(.W(W), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode),
        .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
        .reg_mem0(reg_mem0), .reg_mem1(reg_mem1), .reg_mem2(reg_mem2),
        .reg_mem3(reg_mem3), .reg_mem4(reg_mem4), .reg_mem5(reg_mem5),
        .reg_mem6(reg_mem6), .reg_mem7(reg_mem7), .reg_mem8(reg_mem8),
        .reg_mem9(reg_mem9), .reg_mem10(reg_mem10), .reg_mem11(reg_mem11),
        .reg_mem12(reg_mem12), .reg_mem13(reg_mem13), .reg_mem14(reg_mem14),
        .stat(stat), .wb_busy(wb_busy), .retired(retired)
    );

    logic [W-1:0] act [NREG];
    assign act[0]  = reg_mem0;   assign act[1]  = reg_mem1;
    assign act[2]  = reg_mem2;   assign act[3]  = reg_mem3;
    assign act[4]  = reg_mem4;   assign act[5]  = reg_mem5;
    assign act[6]  = reg_mem6;   assign act[7]  = reg_mem7;
    assign act[8]  = reg_mem8;   assign act[9]  = reg_mem9;
    assign act[10] = reg_mem10;  assign act[11] = reg_mem11;
    assign act[12] = reg_mem12;  assign act[13] = reg_mem13;
    assign act[14] = reg_mem14;

    typedef struct packed {
        logic [NREG-1:0][W-1:0] regs;
        logic [1:0]             st;
        logic [31:0]            ret;
        logic [7:0]             id;
    } snap_t;

    snap_t exp_q [$];

    // Expected architectural state, updated only from hand-written vectors.
    logic [NREG-1:0][W-1:0] exp_regs;
    logic [1:0]             exp_stat;
    logic [31:0]            exp_ret;

    typedef struct packed {
        logic        v;
        logic [3:0]  ic;
        logic        c;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [3:0]  e1_idx;   // 4'hF: no expected write
        logic [63:0] e1_val;
        logic [3:0]  e2_idx;
        logic [63:0] e2_val;
        logic [1:0]  e_stat;
        logic        e_inc;    // expected to count as retired
    } vec_t;

    task automatic cmp(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, a, e);
        end
    endtask

    function automatic logic [31:0] ret_exp(input logic [31:0] r);
`ifdef WB_RETIRE_CNT_EN
        return r;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_now(input string tag, input snap_t s);
        for (int i = 0; i < NREG; i++) begin
            cmp($sformatf("%s_r%0d", tag, i), act[i], s.regs[i]);
        end
        cmp({tag, "_stat"}, {62'd0, stat}, {62'd0, s.st});
        cmp({tag, "_busy"}, {63'd0, wb_busy}, {63'd0, (s.st != 2'b00)});
        cmp({tag, "_retired"}, {32'd0, retired}, {32'd0, ret_exp(s.ret)});
    endtask

    function automatic snap_t cur_snap(input logic [7:0] id);
        snap_t s;
        s.regs = exp_regs;
        s.st   = exp_stat;
        s.ret  = exp_ret;
        s.id   = id;
        return s;
    endfunction

    task automatic model_reset();
        exp_regs = '0;
        exp_stat = 2'b00;
        exp_ret  = 32'd0;
    endtask

    // Monitor: pops one expected snapshot per cycle once stimulus has queued it.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t s;
            s = exp_q.pop_front();
            check_now($sformatf("v%0d", s.id), s);
            $display("txn %0d: stat=%0d retired=%0d r4=0x%0h", s.id, stat, retired, reg_mem4);
        end
    end

    task automatic send(input vec_t vv, input logic [7:0] id);
        @(negedge clk);
        wb_valid = vv.v; icode = vv.ic; cnd = vv.c; rA = vv.ra; rB = vv.rb;
        valE = vv.ve; valM = vv.vm;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        if (vv.e1_idx != 4'hF) exp_regs[vv.e1_idx] = vv.e1_val;
        if (vv.e2_idx != 4'hF) exp_regs[vv.e2_idx] = vv.e2_val;
        exp_stat = vv.e_stat;
        if (vv.e_inc) exp_ret = exp_ret + 32'd1;
        exp_q.push_back(cur_snap(id));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic c,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] ve, input logic [63:0] vm,
                                input logic [3:0] i1, input logic [63:0] v1,
                                input logic [3:0] i2, input logic [63:0] v2,
                                input logic [1:0] es, input logic inc);
        vec_t t;
        t.v = 1'b1; t.ic = ic; t.c = c; t.ra = ra; t.rb = rb; t.ve = ve; t.vm = vm;
        t.e1_idx = i1; t.e1_val = v1; t.e2_idx = i2; t.e2_val = v2;
        t.e_stat = es; t.e_inc = inc;
        return t;
    endfunction

    vec_t va [$];
    vec_t vb [$];
    vec_t vc [$];
    vec_t tmp;

    initial begin
        model_reset();
        // Phase A: cmov, popq, push/call/ret, no-write icodes, full width, halt.
        va.push_back(mk(4'h2, 1'b1, 4'hF, 4'h2, 64'h69,  64'h0,  4'h2, 64'h69, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h2, 1'b0, 4'hF, 4'h2, 64'h55,  64'h0,  4'hF, 64'h0,  4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'hB, 1'b0, 4'h6, 4'hF, 64'h100, 64'h57, 4'h4, 64'h100, 4'h6, 64'h57, 2'b00, 1'b1));
        va.push_back(mk(4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'hAA, 4'h4, 64'hAA, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'hA, 1'b0, 4'h3, 4'hF, 64'h0F8, 64'h0,  4'h4, 64'h0F8, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h8, 1'b0, 4'hF, 4'hF, 64'h0F0, 64'h0,  4'h4, 64'h0F0, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h9, 1'b0, 4'hF, 4'hF, 64'h0F8, 64'h33, 4'h4, 64'h0F8, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h1, 1'b0, 4'h3, 4'h3, 64'h123, 64'h5,  4'hF, 64'h0,  4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h4, 1'b0, 4'h1, 4'h2, 64'h124, 64'h6,  4'hF, 64'h0,  4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h7, 1'b1, 4'h1, 4'h2, 64'h125, 64'h7,  4'hF, 64'h0,  4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h3, 1'b0, 4'hF, 4'h9, 64'h99,  64'h0,  4'h9, 64'h99, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h6, 1'b0, 4'h1, 4'h9, 64'hFEDC_BA98_7654_3210, 64'h0,
                        4'h9, 64'hFEDC_BA98_7654_3210, 4'hF, 64'h0, 2'b00, 1'b1));
        va.push_back(mk(4'h5, 1'b0, 4'hE, 4'h1, 64'h11,  64'h8000_0000_0000_0001,
                        4'hE, 64'h8000_0000_0000_0001, 4'hF, 64'h0, 2'b00, 1'b1));
        tmp = mk(4'h3, 1'b0, 4'hF, 4'h8, 64'h88, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0, 2'b00, 1'b0);
        tmp.v = 1'b0;   // wb_valid low: nothing happens
        va.push_back(tmp);
        va.push_back(mk(4'h0, 1'b0, 4'hF, 4'h5, 64'h5,   64'h6,  4'hF, 64'h0,  4'hF, 64'h0, 2'b01, 1'b1));
        va.push_back(mk(4'h6, 1'b0, 4'h1, 4'h9, 64'hE6,  64'h0,  4'hF, 64'h0,  4'hF, 64'h0, 2'b01, 1'b0));
        va.push_back(mk(4'hB, 1'b0, 4'h6, 4'hF, 64'h1,   64'h2,  4'hF, 64'h0,  4'hF, 64'h0, 2'b01, 1'b0));
        // Phase B: illegal icode and everything after it ignored.
        vb.push_back(mk(4'h3, 1'b0, 4'hF, 4'h7, 64'h77,  64'h0,  4'h7, 64'h77, 4'hF, 64'h0, 2'b00, 1'b1));
        vb.push_back(mk(4'hD, 1'b0, 4'h1, 4'h1, 64'hDD,  64'hDE, 4'hF, 64'h0,  4'hF, 64'h0, 2'b10, 1'b0));
        vb.push_back(mk(4'h3, 1'b0, 4'hF, 4'h1, 64'h1,   64'h0,  4'hF, 64'h0,  4'hF, 64'h0, 2'b10, 1'b0));
        vb.push_back(mk(4'h0, 1'b0, 4'hF, 4'hF, 64'h0,   64'h0,  4'hF, 64'h0,  4'hF, 64'h0, 2'b10, 1'b0));
        // Phase C: icode F is illegal too.
        vc.push_back(mk(4'hF, 1'b0, 4'h2, 4'h2, 64'hF0,  64'hF1, 4'hF, 64'h0,  4'hF, 64'h0, 2'b10, 1'b0));
        vc.push_back(mk(4'h6, 1'b0, 4'h1, 4'h2, 64'hF2,  64'h0,  4'hF, 64'h0,  4'hF, 64'h0, 2'b10, 1'b0));

        // Reset state while rst_n held low.
        #12;
        check_now("reset", cur_snap(8'd0));
        @(negedge clk);
        rst_n = 1'b1;

        // Load R2=0x3E, then assert reset mid-cycle with a write pending.
        send(mk(4'h3, 1'b0, 4'hF, 4'h2, 64'h3E, 64'h0, 4'h2, 64'h3E, 4'hF, 64'h0, 2'b00, 1'b1), 8'd1);
        drain();
        #2;
        wb_valid = 1'b1; icode = 4'h3; rB = 4'h5; valE = 64'h77;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async_rst", cur_snap(8'd0));
        @(posedge clk);
        #1;
        check_now("rst_write_lost", cur_snap(8'd0));
        wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < va.size(); i++) send(va[i], 8'(10 + i));
        drain();

        // Reset pulse leaves HLT.
        rst_n = 1'b0;
        #2;
        model_reset();
        check_now("hlt_rst", cur_snap(8'd0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vb.size(); i++) send(vb[i], 8'(40 + i));
        drain();

        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vc.size(); i++) send(vc[i], 8'(60 + i));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
